// File: rtl/int_controller_if.sv
// Register-bus strobes, raw interrupt lines and the CPU irq of int_controller.
// The 32-bit tristate data bus stays a plain inout port on the controller.
interface int_controller_if #(parameter int NUM_SRC = 8);
  logic [1:0]         reg_sel;
  logic               rd;
  logic               wr;
  logic [NUM_SRC-1:0] irq_src;
  logic               irq;

  modport master (output reg_sel, output rd, output wr, output irq_src, input irq);
  modport slave  (input reg_sel, input rd, input wr, input irq_src, output irq);
endinterface

// File: rtl/int_controller.sv
// Prioritising interrupt controller: latches/masks sources, drives one irq, claim/EOI via reg bus.
// Optional INT_CONTROLLER_ROTATE_PRIO_EN selects round-robin priority instead of fixed (index 0 highest).
module int_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [31:0] data,
  int_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ASSERT, INSERVICE} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] pending, pending_nxt, mask, mode, src_q, eligible;
  logic [4:0]         cur, cur_nxt, winner;
  logic               irq_q, irq_nxt;
  logic               vec_rd, claim, eoi, w1c, mask_wr, mode_wr;
  logic [31:0]        rdata;
  logic               unused_data_hi;

  assign eligible = pending & mask;
  assign vec_rd   = bus.rd && (bus.reg_sel == 2'b00);
  assign eoi      = bus.wr && (bus.reg_sel == 2'b00);
  assign mask_wr  = bus.wr && (bus.reg_sel == 2'b01);
  assign w1c      = bus.wr && (bus.reg_sel == 2'b10);
  assign mode_wr  = bus.wr && (bus.reg_sel == 2'b11);
  assign claim    = (state == ASSERT) && vec_rd && (eligible != '0);
  assign unused_data_hi = ^data[31:NUM_SRC];

`ifdef INT_CONTROLLER_ROTATE_PRIO_EN
  logic [4:0] ptr, ptr_nxt;
  int         idx;
  logic       found;

  // Search starts just after the lowest-priority pointer and wraps.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(ptr) + 1 + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && eligible[idx]) begin
        winner = 5'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_nxt = ptr;
    if (state == INSERVICE && eoi) ptr_nxt = cur;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr <= 5'(NUM_SRC - 1);
    else     ptr <= ptr_nxt;
  end
`else
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 5'(i);
    end
  end
`endif

  // A new edge wins over a same-cycle claim or W1C of the same bit.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (mode[i]) begin
        pending_nxt[i] = (bus.irq_src[i] & ~src_q[i]) |
                         (pending[i] & ~((claim && winner == 5'(i)) || (w1c && data[i])));
      end else begin
        pending_nxt[i] = bus.irq_src[i];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    irq_nxt   = irq_q;
    case (state)
      IDLE: begin
        irq_nxt = 1'b0;
        if (eligible != '0) begin
          state_nxt = ASSERT;
          irq_nxt   = 1'b1;
        end
      end
      ASSERT: begin
        if (eligible == '0) begin
          state_nxt = IDLE;
          irq_nxt   = 1'b0;
        end else if (claim) begin
          state_nxt = INSERVICE;
          cur_nxt   = winner;
          irq_nxt   = 1'b0;
        end
      end
      INSERVICE: begin
        irq_nxt = 1'b0;
        if (eoi) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        irq_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      mask    <= '0;
      mode    <= '1;
      src_q   <= '0;
      cur     <= '0;
      irq_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      src_q   <= bus.irq_src;
      cur     <= cur_nxt;
      irq_q   <= irq_nxt;
      if (mask_wr) mask <= data[NUM_SRC-1:0];
      if (mode_wr) mode <= data[NUM_SRC-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.reg_sel)
      2'b00: begin
        if (state == ASSERT)         rdata = {1'b1, 26'b0, winner};
        else if (state == INSERVICE) rdata = {1'b1, 26'b0, cur};
      end
      2'b01:   rdata = {{(32-NUM_SRC){1'b0}}, mask};
      2'b10:   rdata = {{(32-NUM_SRC){1'b0}}, pending};
      default: rdata = {{(32-NUM_SRC){1'b0}}, mode};
    endcase
  end

  assign data    = bus.rd ? rdata : 'z;
  assign bus.irq = irq_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: reset, level/edge sources, masking, W1C, set-wins and priority order.
module tb_int_controller;
  logic        clk;
  logic        rst;
  wire  [31:0] data;
  logic        drv_en;
  logic [31:0] drv_dat;
  int          checks;
  int          failures;

  int_controller_if #(.NUM_SRC(8)) bus ();

  int_controller #(.NUM_SRC(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .bus  (bus)
  );

  assign data = drv_en ? drv_dat : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] sel, input logic [31:0] val);
    bus.reg_sel = sel;
    drv_dat     = val;
    drv_en      = 1'b1;
    bus.wr      = 1'b1;
    step();
    bus.wr      = 1'b0;
    drv_en      = 1'b0;
  endtask

  // Read without crossing a clock edge, so no claim side effect.
  task automatic peek(input logic [1:0] sel, output logic [31:0] v);
    bus.reg_sel = sel;
    bus.rd      = 1'b1;
    #1;
    v           = data;
    bus.rd      = 1'b0;
    #1;
  endtask

  // VECTOR read held across a clock edge: claims when in ASSERT.
  task automatic claim_rd(output logic [31:0] v);
    bus.reg_sel = 2'b00;
    bus.rd      = 1'b1;
    #1;
    v           = data;
    step();
    bus.rd      = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    step();
    reg_write(2'b01, 32'hFF);
    step();
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL reset_irq got %b exp 0", bus.irq); end
    rst = 1'b0;
    peek(2'b01, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_mask got %h exp 00000000", v); end
    peek(2'b10, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_pending got %h exp 00000000", v); end
    peek(2'b11, v);
    checks++; if (v !== 32'hFF) begin failures++; $display("FAIL reset_mode got %h exp 000000ff", v); end
    peek(2'b00, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_vector got %h exp 00000000", v); end
  endtask

  task automatic test_level();
    logic [31:0] v;
    reg_write(2'b01, 32'h01);
    reg_write(2'b11, 32'h00);
    bus.irq_src = 8'h01;
    step();
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL level_irq_early got %b exp 0", bus.irq); end
    step();
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL level_irq_rise got %b exp 1", bus.irq); end
    claim_rd(v);
    checks++; if (v !== 32'h80000000) begin failures++; $display("FAIL level_vector got %h exp 80000000", v); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL level_irq_claimed got %b exp 0", bus.irq); end
    bus.irq_src = 8'h00;
    reg_write(2'b00, 32'h0);
    step();
    step();
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL level_irq_after_eoi got %b exp 0", bus.irq); end
    peek(2'b00, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL level_idle_vector got %h exp 00000000", v); end
  endtask

  task automatic test_edge_priority();
    logic [31:0] v;
    reg_write(2'b01, 32'hFF);
    reg_write(2'b11, 32'hFF);
    bus.irq_src = 8'h24;
    step();
    bus.irq_src = 8'h00;
    step();
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL edge_irq_rise got %b exp 1", bus.irq); end
    claim_rd(v);
    checks++; if (v !== 32'h80000002) begin failures++; $display("FAIL edge_vector_first got %h exp 80000002", v); end
    peek(2'b00, v);
    checks++; if (v !== 32'h80000002) begin failures++; $display("FAIL edge_inservice_vector got %h exp 80000002", v); end
    reg_write(2'b00, 32'h0);
    step();
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL edge_irq_rerise got %b exp 1", bus.irq); end
    claim_rd(v);
    checks++; if (v !== 32'h80000005) begin failures++; $display("FAIL edge_vector_second got %h exp 80000005", v); end
    reg_write(2'b00, 32'h0);
    step();
    peek(2'b10, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL edge_pending_empty got %h exp 00000000", v); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL edge_irq_quiet got %b exp 0", bus.irq); end
  endtask

  task automatic test_mask_w1c();
    logic [31:0] v;
    reg_write(2'b01, 32'h00);
    bus.irq_src = 8'h08;
    step();
    bus.irq_src = 8'h00;
    step();
    peek(2'b10, v);
    checks++; if (v !== 32'h08) begin failures++; $display("FAIL mask_pending got %h exp 00000008", v); end
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL mask_irq_masked got %b exp 0", bus.irq); end
    reg_write(2'b01, 32'h08);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL mask_irq_delay got %b exp 0", bus.irq); end
    step();
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL mask_irq_unmasked got %b exp 1", bus.irq); end
    reg_write(2'b10, 32'h08);
    step();
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_drop got %b exp 0", bus.irq); end
    peek(2'b10, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL w1c_pending got %h exp 00000000", v); end
    peek(2'b00, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL w1c_vector_idle got %h exp 00000000", v); end
  endtask

  task automatic test_set_wins();
    logic [31:0] v;
    reg_write(2'b01, 32'h02);
    bus.irq_src = 8'h02;
    step();
    bus.irq_src = 8'h00;
    step();
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL setwins_irq_rise got %b exp 1", bus.irq); end
    bus.irq_src = 8'h02;
    claim_rd(v);
    bus.irq_src = 8'h00;
    checks++; if (v !== 32'h80000001) begin failures++; $display("FAIL setwins_vector got %h exp 80000001", v); end
    peek(2'b10, v);
    checks++; if (v !== 32'h02) begin failures++; $display("FAIL setwins_pending got %h exp 00000002", v); end
    reg_write(2'b00, 32'h0);
    step();
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL setwins_irq_again got %b exp 1", bus.irq); end
    peek(2'b00, v);
    checks++; if (v !== 32'h80000001) begin failures++; $display("FAIL setwins_vector_again got %h exp 80000001", v); end
    claim_rd(v);
    reg_write(2'b00, 32'h0);
  endtask

  task automatic test_priority_order();
    logic [31:0] v;
    logic [31:0] exp_vec [3];
`ifdef INT_CONTROLLER_ROTATE_PRIO_EN
    exp_vec[0] = 32'h80000000; exp_vec[1] = 32'h80000001; exp_vec[2] = 32'h80000000;
`else
    exp_vec[0] = 32'h80000000; exp_vec[1] = 32'h80000000; exp_vec[2] = 32'h80000000;
`endif
    reg_write(2'b01, 32'hFF);
    for (int r = 0; r < 3; r++) begin
      bus.irq_src = 8'h03;
      step();
      bus.irq_src = 8'h00;
      step();
      checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL prio_irq_round%0d got %b exp 1", r, bus.irq); end
      claim_rd(v);
      checks++; if (v !== exp_vec[r]) begin failures++; $display("FAIL prio_vector_round%0d got %h exp %h", r, v, exp_vec[r]); end
      reg_write(2'b00, 32'h0);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    drv_en      = 1'b0;
    drv_dat     = '0;
    bus.reg_sel = 2'b00;
    bus.rd      = 1'b0;
    bus.wr      = 1'b0;
    bus.irq_src = '0;
    test_reset();
    test_level();
    test_edge_priority();
    test_mask_w1c();
    test_set_wins();
    test_priority_order();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
